// File: rtl/spi_ram_protocol_monitor_if.sv
// Command/response taps between the SPI slave and the single-port RAM.
// Ports: din (opcode + payload), rx_valid (din valid), tx_valid (read data valid).
interface spi_ram_protocol_monitor_if #(
    parameter int ADDR_SIZE = 8
) ();
    logic [ADDR_SIZE+1:0] din;
    logic                 rx_valid;
    logic                 tx_valid;

    modport master (
        output din,
        output rx_valid,
        output tx_valid
    );

    modport slave (
        input din,
        input rx_valid,
        input tx_valid
    );
endinterface

// File: rtl/spi_ram_protocol_monitor.sv
// Passive SPI-RAM command protocol monitor: sequence and read-timing checks.
// Ports: clk, rst_n, bus (slave taps), clr_err, sticky err_* flags, err_any, err_count.
module spi_ram_protocol_monitor #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_LATENCY = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_ram_protocol_monitor_if.slave bus,
    input  logic                 clr_err,
    output logic                 err_seq_wr,
    output logic                 err_seq_rd,
    output logic                 err_tx_miss,
    output logic                 err_tx_spur,
    output logic                 err_any,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WA_SEEN = 2'd1,
        RA_SEEN = 2'd2
    } state_e;

    localparam logic [1:0] OP_WA = 2'b00;
    localparam logic [1:0] OP_WD = 2'b01;
    localparam logic [1:0] OP_RA = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    localparam int SUM_W = ERR_CNT_W + 3;
    localparam logic [SUM_W-1:0] CNT_MAX = {3'b000, {ERR_CNT_W{1'b1}}};

    state_e                state_q, state_d;
    logic [RD_LATENCY-1:0] exp_q, exp_d;
    logic [RD_LATENCY:0]   exp_ext;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic                  miss_q, miss_d;
    logic                  spur_q, spur_d;
    logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]            op;
    logic                  push;
    logic                  ev_wr, ev_rd, ev_miss, ev_spur;
    logic                  exp_due;
    logic [2:0]            n_ev;
    logic [ERR_CNT_W-1:0]  cnt_base;
    logic [SUM_W-1:0]      cnt_sum;
    logic                  unused_payload;

    assign op             = bus.din[ADDR_SIZE+1:ADDR_SIZE];
    assign unused_payload = ^bus.din[ADDR_SIZE-1:0];

    // Command sequencing; an abandoned sequence is charged to the
    // sequence that was open, a stray data command to its own kind.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        ev_wr   = 1'b0;
        ev_rd   = 1'b0;
        if (bus.rx_valid) begin
            unique case (op)
                OP_WA: begin
                    state_d = WA_SEEN;
                    ev_rd   = (state_q == RA_SEEN);
                end
                OP_RA: begin
                    state_d = RA_SEEN;
                    ev_wr   = (state_q == WA_SEEN);
                end
                OP_WD: begin
                    if (state_q == WA_SEEN) begin
                        state_d = IDLE;
                    end else begin
                        ev_wr = 1'b1;
                        ev_rd = (state_q == RA_SEEN);
                    end
                end
                OP_RD: begin
                    if (state_q == RA_SEEN) begin
                        state_d = IDLE;
                        push    = 1'b1;
                    end else begin
                        ev_rd = 1'b1;
                        ev_wr = (state_q == WA_SEEN);
                    end
                end
                default: ;
            endcase
        end
    end

    // One bit per outstanding read; the top stage is the one due now.
    always_comb begin
        exp_ext = {exp_q, push};
        exp_d   = exp_ext[RD_LATENCY-1:0];
    end

    assign exp_due = exp_q[RD_LATENCY-1];
    assign ev_miss = exp_due & ~bus.tx_valid;
    assign ev_spur = ~exp_due & bus.tx_valid;

    // clr_err wipes history but still records this cycle's events.
    always_comb begin
        n_ev = {2'b00, ev_wr} + {2'b00, ev_rd}
             + {2'b00, ev_miss} + {2'b00, ev_spur};
        cnt_base = clr_err ? '0 : cnt_q;
        cnt_sum  = {3'b000, cnt_base} + {{ERR_CNT_W{1'b0}}, n_ev};
        cnt_d    = (cnt_sum > CNT_MAX) ? CNT_MAX[ERR_CNT_W-1:0]
                                       : cnt_sum[ERR_CNT_W-1:0];
        wr_d     = (wr_q   & ~clr_err) | ev_wr;
        rd_d     = (rd_q   & ~clr_err) | ev_rd;
        miss_d   = (miss_q & ~clr_err) | ev_miss;
        spur_d   = (spur_q & ~clr_err) | ev_spur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            miss_q  <= 1'b0;
            spur_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            miss_q  <= miss_d;
            spur_q  <= spur_d;
            cnt_q   <= cnt_d;
        end
    end

    assign err_seq_wr  = wr_q;
    assign err_seq_rd  = rd_q;
    assign err_tx_miss = miss_q;
    assign err_tx_spur = spur_q;
    assign err_any     = wr_q | rd_q | miss_q | spur_q;
    assign err_count   = cnt_q;

endmodule

// File: tb/tb_spi_ram_protocol_monitor.sv
// Directed bench for spi_ram_protocol_monitor with three parameter sets.
// dut0: latency 1 / 8-bit count, dut1: latency 3, dut2: 2-bit count.
module tb_spi_ram_protocol_monitor;

    localparam logic [1:0] WA = 2'b00;
    localparam logic [1:0] WD = 2'b01;
    localparam logic [1:0] RA = 2'b10;
    localparam logic [1:0] RD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [2:0] tx_v = '0;
    logic       clr_err = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_ram_protocol_monitor_if #(.ADDR_SIZE(8)) if0 ();
    spi_ram_protocol_monitor_if #(.ADDR_SIZE(8)) if1 ();
    spi_ram_protocol_monitor_if #(.ADDR_SIZE(8)) if2 ();

    assign if0.din = din;
    assign if1.din = din;
    assign if2.din = din;
    assign if0.rx_valid = rx_valid;
    assign if1.rx_valid = rx_valid;
    assign if2.rx_valid = rx_valid;
    assign if0.tx_valid = tx_v[0];
    assign if1.tx_valid = tx_v[1];
    assign if2.tx_valid = tx_v[2];

    logic       wr0, rd0, ms0, sp0, any0;
    logic       wr1, rd1, ms1, sp1, any1;
    logic       wr2, rd2, ms2, sp2, any2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic [3:0] f0, f1, f2;

    assign f0 = {wr0, rd0, ms0, sp0};
    assign f1 = {wr1, rd1, ms1, sp1};
    assign f2 = {wr2, rd2, ms2, sp2};

    spi_ram_protocol_monitor #(.ADDR_SIZE(8), .RD_LATENCY(1), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .clr_err(clr_err),
        .err_seq_wr(wr0), .err_seq_rd(rd0), .err_tx_miss(ms0),
        .err_tx_spur(sp0), .err_any(any0), .err_count(c0)
    );

    spi_ram_protocol_monitor #(.ADDR_SIZE(8), .RD_LATENCY(3), .ERR_CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .clr_err(clr_err),
        .err_seq_wr(wr1), .err_seq_rd(rd1), .err_tx_miss(ms1),
        .err_tx_spur(sp1), .err_any(any1), .err_count(c1)
    );

    spi_ram_protocol_monitor #(.ADDR_SIZE(8), .RD_LATENCY(1), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .clr_err(clr_err),
        .err_seq_wr(wr2), .err_seq_rd(rd2), .err_tx_miss(ms2),
        .err_tx_spur(sp2), .err_any(any2), .err_count(c2)
    );

    // Drives one cycle of inputs on the falling edge.
    task automatic step(input logic rx, input logic [1:0] op,
                        input logic [7:0] d, input logic [2:0] tx,
                        input logic clr);
        @(negedge clk);
        rx_valid = rx;
        din      = {op, d};
        tx_v     = tx;
        clr_err  = clr;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 8'h00, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        tx_v = '0;
        clr_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({f0, f1, f2} !== 12'h000) begin
            $display("FAIL reset_flags got %h want 000", {f0, f1, f2});
            fails++;
        end
        tests++;
        if ({c0, c1, c2, any0, any1, any2} !== 21'h0) begin
            $display("FAIL reset_counts got %h want 0", {c0, c1, c2});
            fails++;
        end
        step(1'b0, 2'b00, 8'h00, 3'b001, 1'b0);
        idle();
        tests++;
        if (f0 !== 4'b0001 || c0 !== 8'd1 || any0 !== 1'b1) begin
            $display("FAIL spur_after_reset got f=%b c=%0d want f=0001 c=1", f0, c0);
            fails++;
        end
    endtask

    task automatic test_legal_rw();
        do_reset();
        step(1'b1, WA, 8'h05, 3'b000, 1'b0);
        step(1'b1, WD, 8'hAA, 3'b000, 1'b0);
        step(1'b1, RA, 8'h05, 3'b000, 1'b0);
        step(1'b1, RD, 8'h00, 3'b000, 1'b0);
        step(1'b0, 2'b00, 8'h00, 3'b101, 1'b0);
        idle();
        tests++;
        if (f0 !== 4'b0000 || c0 !== 8'd0 || any0 !== 1'b0) begin
            $display("FAIL legal_rw got f=%b c=%0d want f=0000 c=0", f0, c0);
            fails++;
        end
        tests++;
        if (f2 !== 4'b0000 || c2 !== 2'd0) begin
            $display("FAIL legal_rw_w2 got f=%b c=%0d want f=0000 c=0", f2, c2);
            fails++;
        end
    endtask

    task automatic test_seq_wr();
        do_reset();
        step(1'b1, WD, 8'h11, 3'b000, 1'b0);
        idle();
        tests++;
        if (f0 !== 4'b1000 || c0 !== 8'd1 || any0 !== 1'b1) begin
            $display("FAIL stray_wd got f=%b c=%0d want f=1000 c=1", f0, c0);
            fails++;
        end
        step(1'b1, WA, 8'h01, 3'b000, 1'b0);
        step(1'b1, WD, 8'h02, 3'b000, 1'b0);
        idle();
        tests++;
        if (f0 !== 4'b1000 || c0 !== 8'd1) begin
            $display("FAIL idle_kept got f=%b c=%0d want f=1000 c=1", f0, c0);
            fails++;
        end
    endtask

    task automatic test_tx_miss_spur();
        do_reset();
        step(1'b1, RA, 8'h07, 3'b000, 1'b0);
        step(1'b1, RD, 8'h00, 3'b000, 1'b0);
        idle();
        tests++;
        if (f0 !== 4'b0000) begin
            $display("FAIL miss_early got f=%b want f=0000", f0);
            fails++;
        end
        idle();
        tests++;
        if (f0 !== 4'b0010 || c0 !== 8'd1) begin
            $display("FAIL miss got f=%b c=%0d want f=0010 c=1", f0, c0);
            fails++;
        end
        step(1'b0, 2'b00, 8'h00, 3'b001, 1'b0);
        idle();
        tests++;
        if (f0 !== 4'b0011 || c0 !== 8'd2) begin
            $display("FAIL spur got f=%b c=%0d want f=0011 c=2", f0, c0);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, RA, 8'h01, 3'b000, 1'b0);
        step(1'b1, RD, 8'h00, 3'b000, 1'b0);
        step(1'b1, RA, 8'h02, 3'b001, 1'b0);
        step(1'b1, RD, 8'h00, 3'b000, 1'b0);
        step(1'b0, 2'b00, 8'h00, 3'b001, 1'b0);
        idle();
        tests++;
        if (f0 !== 4'b0000 || c0 !== 8'd0) begin
            $display("FAIL b2b_lat1 got f=%b c=%0d want f=0000 c=0", f0, c0);
            fails++;
        end
    endtask

    task automatic test_latency3(input logic drop);
        do_reset();
        step(1'b1, RA, 8'h01, 3'b000, 1'b0);
        step(1'b1, RD, 8'h00, 3'b000, 1'b0);
        step(1'b1, RA, 8'h02, 3'b000, 1'b0);
        step(1'b1, RD, 8'h00, 3'b000, 1'b0);
        step(1'b0, 2'b00, 8'h00, 3'b010, 1'b0);
        idle();
        step(1'b0, 2'b00, 8'h00, {1'b0, ~drop, 1'b0}, 1'b0);
        idle();
        idle();
        idle();
        tests++;
        if (!drop && (f1 !== 4'b0000 || c1 !== 8'd0)) begin
            $display("FAIL lat3_ok got f=%b c=%0d want f=0000 c=0", f1, c1);
            fails++;
        end else if (drop && (f1 !== 4'b0010 || c1 !== 8'd1)) begin
            $display("FAIL lat3_drop got f=%b c=%0d want f=0010 c=1", f1, c1);
            fails++;
        end
    endtask

    task automatic test_saturate_clear();
        do_reset();
        step(1'b1, WD, 8'h00, 3'b000, 1'b0);
        step(1'b1, WD, 8'h00, 3'b000, 1'b0);
        idle();
        tests++;
        if (c2 !== 2'd2) begin
            $display("FAIL sat_mid got c=%0d want c=2", c2);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, WD, 8'h00, 3'b000, 1'b0);
        end
        idle();
        tests++;
        if (c2 !== 2'd3 || f2 !== 4'b1000) begin
            $display("FAIL sat got f=%b c=%0d want f=1000 c=3", f2, c2);
            fails++;
        end
        tests++;
        if (c0 !== 8'd6) begin
            $display("FAIL wide_count got c=%0d want c=6", c0);
            fails++;
        end
        step(1'b0, 2'b00, 8'h00, 3'b000, 1'b1);
        idle();
        tests++;
        if (c2 !== 2'd0 || f2 !== 4'b0000 || any2 !== 1'b0) begin
            $display("FAIL clr got f=%b c=%0d want f=0000 c=0", f2, c2);
            fails++;
        end
        step(1'b1, WD, 8'h00, 3'b000, 1'b1);
        idle();
        tests++;
        if (c2 !== 2'd1 || f2 !== 4'b1000) begin
            $display("FAIL clr_event got f=%b c=%0d want f=1000 c=1", f2, c2);
            fails++;
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        step(1'b1, WD, 8'h00, 3'b000, 1'b0);
        step(1'b1, RA, 8'h03, 3'b000, 1'b0);
        step(1'b1, RD, 8'h00, 3'b000, 1'b0);
        @(negedge clk);
        tests++;
        if (c0 !== 8'd1 || f0 !== 4'b1000) begin
            $display("FAIL pre_rst got f=%b c=%0d want f=1000 c=1", f0, c0);
            fails++;
        end
        rst_n = 1'b0;
        rx_valid = 1'b0;
        tx_v = '0;
        #1;
        tests++;
        if (f0 !== 4'b0000 || c0 !== 8'd0 || any0 !== 1'b0) begin
            $display("FAIL async_rst got f=%b c=%0d want f=0000 c=0", f0, c0);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        idle();
        tests++;
        if (f0 !== 4'b0000 || c0 !== 8'd0) begin
            $display("FAIL dropped_exp got f=%b c=%0d want f=0000 c=0", f0, c0);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_legal_rw();
        test_seq_wr();
        test_tx_miss_spur();
        test_back_to_back();
        test_latency3(1'b0);
        test_latency3(1'b1);
        test_saturate_clear();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
